// File: rtl/serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// serial_magnitude_comparator
// Bit-serial unsigned magnitude comparator. Operands are captured on an
// in_valid/in_ready handshake, compared one bit pair per clock MSB first,
// and the eq/neq/l/g flags are held under an out_valid/out_ready handshake.
//
// Parameters:
//   WIDTH      operand width in bits (1..32)
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands a/b presented
//   in_ready   block accepts operands (IDLE only)
//   a, b       unsigned operands
//   out_valid  result flags valid (DONE only)
//   out_ready  consumer takes the result
//   eq,neq,l,g result flags: a==b, a!=b, a<b, a>b
//   busy       comparison in progress
//
// Build option:
//   SERIAL_CMP_EARLY_EXIT_EN  finish as soon as the deciding bit is seen;
//                             when undefined, always spend WIDTH compare edges.
// ---------------------------------------------------------------------------
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             neq,
    output logic             l,
    output logic             g,
    output logic             busy
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_lt;
    logic               r_gt;
    logic               r_eq;
    logic               r_neq;
    logic               r_l;
    logic               r_g;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_lt_nxt;
    logic               w_gt_nxt;
    logic               w_eq_nxt;
    logic               w_neq_nxt;
    logic               w_l_nxt;
    logic               w_g_nxt;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;

    logic               w_bit_lt;
    logic               w_bit_gt;
    logic               w_dec_lt;
    logic               w_dec_gt;
    logic               w_last;

    // Operands shift left each compare edge, so the current bit is always the MSB.
    assign w_bit_lt = ~r_a[WIDTH-1] &  r_b[WIDTH-1];
    assign w_bit_gt =  r_a[WIDTH-1] & ~r_b[WIDTH-1];

    // First differing bit wins; once decided, later bits cannot flip the result.
    assign w_dec_lt = r_lt | (~r_gt & w_bit_lt);
    assign w_dec_gt = r_gt | (~r_lt & w_bit_gt);
    assign w_last   = (r_idx == IDX_W'(0));

    // State and datapath register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_lt        <= 1'b0;
            r_gt        <= 1'b0;
            r_eq        <= 1'b0;
            r_neq       <= 1'b0;
            r_l         <= 1'b0;
            r_g         <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_idx       <= w_idx_nxt;
            r_lt        <= w_lt_nxt;
            r_gt        <= w_gt_nxt;
            r_eq        <= w_eq_nxt;
            r_neq       <= w_neq_nxt;
            r_l         <= w_l_nxt;
            r_g         <= w_g_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_idx_nxt       = r_idx;
        w_lt_nxt        = r_lt;
        w_gt_nxt        = r_gt;
        w_eq_nxt        = r_eq;
        w_neq_nxt       = r_neq;
        w_l_nxt         = r_l;
        w_g_nxt         = r_g;

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_idx_nxt   = IDX_W'(WIDTH - 1);
                    w_lt_nxt    = 1'b0;
                    w_gt_nxt    = 1'b0;
                    w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_a_nxt  = r_a << 1;
                w_b_nxt  = r_b << 1;
                w_lt_nxt = w_dec_lt;
                w_gt_nxt = w_dec_gt;
                if (!w_last) begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
                if (w_last || (EARLY_EXIT && (w_dec_lt || w_dec_gt))) begin
                    w_l_nxt     = w_dec_lt;
                    w_g_nxt     = w_dec_gt;
                    w_neq_nxt   = w_dec_lt | w_dec_gt;
                    w_eq_nxt    = ~(w_dec_lt | w_dec_gt);
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt      = (w_state_nxt == S_COMPARE);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign eq        = r_eq;
    assign neq       = r_neq;
    assign l         = r_l;
    assign g         = r_g;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_magnitude_comparator
// Self-checking bench: a WIDTH=8 instance and a WIDTH=1 instance share clk
// and rst_n. Expected flags and latency come from a behavioural model pushed
// to a scoreboard queue on accept and popped when out_valid appears.
// Follows SERIAL_CMP_EARLY_EXIT_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

    localparam int W = 8;

    typedef struct {
        logic [3:0] flags;   // {eq, neq, l, g}
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [W-1:0] a8, b8;
    logic         eq8, neq8, l8, g8;
    logic [3:0]   flags8;
    assign flags8 = {eq8, neq8, l8, g8};

    serial_magnitude_comparator #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .eq(eq8), .neq(neq8), .l(l8), .g(g8),
        .busy(busy8)
    );

    // WIDTH=1 instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [0:0] a1, b1;
    logic       eq1, neq1, l1, g1;
    logic [3:0] flags1;
    assign flags1 = {eq1, neq1, l1, g1};

    serial_magnitude_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .eq(eq1), .neq(neq1), .l(l1), .g(g1),
        .busy(busy1)
    );

    exp_t sb8[$];
    exp_t sb1[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: flags from plain arithmetic, latency from the build option.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.flags = {a == b, a != b, a < b, a > b};
        e.lat   = w;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                e.lat = w - i;
                break;
            end
        end
`endif
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({in_ready8, out_valid8, busy8, flags8} !== 7'b100_0000) begin
            fails++;
            $display("FAIL reset8: {in_ready,out_valid,busy,eq,neq,l,g} got %b expected 1000000",
                     {in_ready8, out_valid8, busy8, flags8});
        end
        tests++;
        if ({in_ready1, out_valid1, busy1, flags1} !== 7'b100_0000) begin
            fails++;
            $display("FAIL reset1: {in_ready,out_valid,busy,eq,neq,l,g} got %b expected 1000000",
                     {in_ready1, out_valid1, busy1, flags1});
        end
        rst_n = 1'b1;
    endtask

    // One transaction on the 8-bit DUT. scramble: toggle a/b/in_valid during
    // COMPARE. hold: cycles to stall out_ready while offering new operands.
    task automatic test_compare(input string name, input logic [7:0] a, input logic [7:0] b,
                                input bit scramble, input int hold);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        for (int k = 0; k < 20 && !in_ready8; k++) @(negedge clk);
        tests++;
        if (in_ready8 !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready: in_ready got %b expected 1", name, in_ready8);
            return;
        end
        a8 = a; b8 = b; in_valid8 = 1'b1;
        sb8.push_back(model(W, 32'(a), 32'(b)));
        @(posedge clk);                      // accept edge E0
        @(negedge clk);
        in_valid8 = 1'b0;
        if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'b1;
        end
        tests++;
        if (busy8 !== 1'b1) begin
            fails++;
            $display("FAIL %s_busy: busy got %b expected 1", name, busy8);
        end
        lat = 0; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid8 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        e = sb8.pop_front();
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: out_valid never rose, expected after %0d edges", name, e.lat);
            in_valid8 = 1'b0;
            return;
        end
        if (lat != e.lat) begin
            fails++;
            $display("FAIL %s_latency: got %0d edges expected %0d", name, lat, e.lat);
        end
        tests++;
        if (flags8 !== e.flags) begin
            fails++;
            $display("FAIL %s_flags: {eq,neq,l,g} got %b expected %b", name, flags8, e.flags);
        end
        tests++;
        if ({in_ready8, busy8} !== 2'b00) begin
            fails++;
            $display("FAIL %s_done_ctrl: {in_ready,busy} got %b expected 00", name, {in_ready8, busy8});
        end
        // Stall the result while new operands are offered; nothing may move.
        in_valid8 = (hold > 0);
        a8 = 8'h00; b8 = 8'hFF;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if ({out_valid8, in_ready8, busy8, flags8} !== {3'b100, e.flags}) begin
                fails++;
                $display("FAIL %s_stall%0d: {out_valid,in_ready,busy,flags} got %b expected %b",
                         name, k, {out_valid8, in_ready8, busy8, flags8}, {3'b100, e.flags});
            end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
        tests++;
        if ({out_valid8, in_ready8, busy8, flags8} !== {3'b010, e.flags}) begin
            fails++;
            $display("FAIL %s_idle: {out_valid,in_ready,busy,flags} got %b expected %b",
                     name, {out_valid8, in_ready8, busy8, flags8}, {3'b010, e.flags});
        end
    endtask

    // Reset on the third compare edge discards the operation.
    task automatic test_reset_abort();
        @(negedge clk);
        for (int k = 0; k < 20 && !in_ready8; k++) @(negedge clk);
        a8 = 8'h0F; b8 = 8'h0E; in_valid8 = 1'b1;
        @(posedge clk);                      // E0
        @(negedge clk);
        in_valid8 = 1'b0;
        @(posedge clk);                      // E1
        @(posedge clk);                      // E2
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);                      // E3 with reset
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({in_ready8, out_valid8, busy8, flags8} !== 7'b100_0000) begin
            fails++;
            $display("FAIL abort: {in_ready,out_valid,busy,eq,neq,l,g} got %b expected 1000000",
                     {in_ready8, out_valid8, busy8, flags8});
        end
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid8 !== 1'b0) break;
        end
        tests++;
        if (out_valid8 !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_result: out_valid got %b expected 0", out_valid8);
        end
        test_compare("after_abort", 8'h01, 8'h02, 1'b0, 0);
    endtask

    task automatic test_width1();
        logic [1:0] cases [3];
        exp_t e;
        int   lat;
        bit   seen;
        cases[0] = 2'b01; cases[1] = 2'b11; cases[2] = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 20 && !in_ready1; k++) @(negedge clk);
            a1 = cases[c][1]; b1 = cases[c][0]; in_valid1 = 1'b1;
            sb1.push_back(model(1, 32'(a1), 32'(b1)));
            @(posedge clk);
            @(negedge clk);
            in_valid1 = 1'b0;
            lat = 0; seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (out_valid1 === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            e = sb1.pop_front();
            tests++;
            if (!seen || lat != e.lat) begin
                fails++;
                $display("FAIL w1_case%0d_latency: seen=%0d got %0d edges expected %0d", c, seen, lat, e.lat);
            end
            tests++;
            if (flags1 !== e.flags) begin
                fails++;
                $display("FAIL w1_case%0d_flags: {eq,neq,l,g} got %b expected %b", c, flags1, e.flags);
            end
            out_ready1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_compare("equal_a5", 8'hA5, 8'hA5, 1'b0, 0);
        test_compare("gt_80_7f", 8'h80, 8'h7F, 1'b0, 0);
        test_compare("lt_12_13", 8'h12, 8'h13, 1'b0, 0);
        test_compare("stall", 8'h80, 8'h7F, 1'b0, 5);
        test_compare("ignore_inputs", 8'h3C, 8'h3D, 1'b1, 0);
        test_compare("zero_max", 8'h00, 8'hFF, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            test_compare("random", 8'($urandom), 8'($urandom), 1'b1, i % 2);
        end
        test_reset_abort();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a/b are presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: unsigned operands.
REQ-007 The block SHALL have port out_valid, output, 1 bit: result flags are valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-009 The block SHALL have ports eq, neq, l, g, output, 1 bit each: a==b, a!=b, a<b, a>b.
REQ-010 The block SHALL have port busy, output, 1 bit: a comparison is in progress (state COMPARE).

Function
REQ-011 The block SHALL implement states IDLE, COMPARE, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge.
REQ-013 On accept, the block SHALL capture a and b into internal registers, clear the bit index to WIDTH-1, and enter COMPARE; later changes on a/b SHALL be ignored.
REQ-014 At each COMPARE edge, the block SHALL evaluate one bit pair, MSB first: per-bit lt = ~a_i & b_i, gt = a_i & ~b_i, then decrement the index.
REQ-015 The first bit with lt or gt SHALL decide the result (l or g latched to 1); later bits SHALL NOT change a decided result.
REQ-016 If no bit differs after bit 0, the result SHALL be eq=1, neq=0, l=0, g=0.
REQ-017 Flags SHALL always satisfy neq = l | g and eq = ~neq when out_valid=1; exactly one of eq, l, g is 1.
REQ-018 Latency SHALL be counted in edges from the accept edge (E0) to the edge that enters DONE; out_valid SHALL rise directly after that edge.
REQ-019 In DONE, out_valid SHALL be 1 and flags SHALL stay stable until out_valid & out_ready at an edge, which returns the block to IDLE.
REQ-020 The block SHALL NOT accept new operands in the same cycle as DONE->IDLE; in_ready rises the cycle after the handshake.
REQ-021 in_valid asserted in COMPARE or DONE SHALL be ignored with no effect on state or flags.
REQ-022 Flags SHALL be registered and SHALL hold their last result in IDLE; out_valid is 0 outside DONE.

Reset
REQ-023 With rst_n=0 at an edge, the block SHALL enter IDLE: in_ready=1, out_valid=0, busy=0, eq=neq=l=g=0, operand registers and index cleared.
REQ-024 Reset mid-COMPARE or in DONE SHALL abort the operation with no result delivered.

Configuration
REQ-025 Macro SERIAL_CMP_EARLY_EXIT_EN defined: the block SHALL enter DONE on the edge that evaluates the deciding bit, so latency = (WIDTH - i) edges for deciding bit i, WIDTH for equal operands.
REQ-026 Macro SERIAL_CMP_EARLY_EXIT_EN undefined: the block SHALL always spend WIDTH edges in COMPARE, so latency = WIDTH edges regardless of operands, with the result per REQ-015.

Verification (WIDTH=8 unless stated)
REQ-027 a=0xA5, b=0xA5 -> out_valid after 8 edges; eq=1, neq=0, l=0, g=0 (both configurations).
REQ-028 a=0x80, b=0x7F -> g=1, neq=1, eq=0, l=0; latency 1 edge with the macro, 8 without.
REQ-029 a=0x12, b=0x13 -> l=1, neq=1, eq=0, g=0; latency 8 edges in both configurations.
REQ-030 Result pending, out_ready=0 for 5 cycles with in_valid=1, a=0x00, b=0xFF -> flags stable, in_ready=0, no accept; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-031 a=0x0F, b=0x0E (no macro), rst_n=0 at the 3rd COMPARE edge -> all outputs 0, in_ready=1; the next compare a=0x01, b=0x02 gives l=1 after 8 edges.
REQ-032 WIDTH=1, a=0, b=1 -> l=1, neq=1 after 1 edge; a=1, b=1 -> eq=1 after 1 edge.
